// File: rtl/seq_multiplier.sv
// seq_multiplier
//   Sequential shift-add multiplier. One WIDTH x WIDTH operand pair is accepted
//   in IDLE. BITS_PER_CYCLE multiplier bits are retired on each BUSY edge, so
//   the product is ready after N = WIDTH/BITS_PER_CYCLE cycles. The full
//   2*WIDTH-bit product is then held in DONE until the consumer accepts it.
//
//   Optional feature: define SEQ_MULTIPLIER_SIGNED_EN to treat a/b as two's
//   complement. Magnitudes are latched, the unsigned iteration runs, and the sum
//   is negated at the final load when the operand signs differ. Latency is the
//   same in both builds.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  operand handshake (in_ready high only in IDLE)
//   a, b                multiplicand / multiplier, WIDTH bits
//   out_valid, out_ready product handshake (out_valid high only in DONE)
//   p                   registered product, 2*WIDTH bits, held until next load
//   busy                high while iterating
module seq_multiplier #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N + 1) : 1;
    localparam int PW    = 2 * WIDTH;

    generate
        if (WIDTH < 2)
            $error("seq_multiplier: WIDTH must be at least 2");
        if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4)
            $error("seq_multiplier: BITS_PER_CYCLE must be 1, 2 or 4");
        if ((WIDTH % BITS_PER_CYCLE) != 0)
            $error("seq_multiplier: BITS_PER_CYCLE must divide WIDTH");
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   b_shift;
    logic [PW-1:0]      acc;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   a_op, b_op;
    logic [PW-1:0]      pp, sum, fin;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
    logic               sign;

    // -(-2^(W-1)) wraps back to 2^(W-1), which is the correct magnitude when the
    // W-bit register is read as unsigned.
    always_comb begin
        a_op = a[WIDTH-1] ? -a : a;
        b_op = b[WIDTH-1] ? -b : b;
    end
`else
    always_comb begin
        a_op = a;
        b_op = b;
    end
`endif

    // Partial product for the low BITS_PER_CYCLE multiplier bits, aligned to
    // the weight of the bits being retired on this cycle.
    always_comb begin
        pp  = ({{WIDTH{1'b0}}, mcand} *
               {{(PW-BITS_PER_CYCLE){1'b0}}, b_shift[BITS_PER_CYCLE-1:0]})
              << (32'(cnt) * BITS_PER_CYCLE);
        sum = acc + pp;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        fin = sign ? -sum : sum;
`else
        fin = sum;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mcand     <= '0;
            b_shift   <= '0;
            acc       <= '0;
            cnt       <= '0;
            p         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            sign      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= a_op;
                        b_shift  <= b_op;
                        acc      <= '0;
                        cnt      <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
                        sign     <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    acc     <= sum;
                    b_shift <= b_shift >> BITS_PER_CYCLE;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(N - 1)) begin
                        p         <= fin;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

    localparam int W   = 8;
    localparam int BPC = 2;
    localparam int N   = W / BPC;

    logic          clk, rst_n;
    logic          in_valid, in_ready;
    logic [W-1:0]  a, b;
    logic          out_valid, out_ready;
    logic [2*W-1:0] p;
    logic          busy;

    seq_multiplier #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain integer multiplication of the operands as the block interprets them.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        logic signed [2*W-1:0] sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        return sx * sy;
`else
        return {{W{1'b0}}, x} * {{W{1'b0}}, y};
`endif
    endfunction

    typedef struct {
        logic [2*W-1:0] prod;
        int             acc;
    } exp_t;
    exp_t q[$];

    // ---------------- monitor ----------------
    bit             have = 0;
    bit             hs_pending = 0;
    int             stall = 0;
    int             force_stall = 0;
    logic [2*W-1:0] held;
    exp_t           e;

    always @(negedge clk) begin
        if (!rst_n) begin
            have = 0; hs_pending = 0; stall = 0; out_ready = 1'b0;
        end else if (hs_pending) begin
            // handshake edge just passed: block must be back in IDLE
            check("in_ready_after_hs", in_ready, 1);
            check("out_valid_after_hs", out_valid, 0);
            hs_pending = 0;
            out_ready = 1'($urandom_range(0, 1));
        end else if (out_valid) begin
            if (!have) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("product", p, e.prod);
                    check("latency", cyc - e.acc, N);
                end
                held  = p;
                have  = 1;
                stall = (force_stall != 0) ? force_stall : int'($urandom_range(0, 2));
                force_stall = 0;
            end else begin
                check("p_stable", p, held);
                check("in_ready_in_done", in_ready, 0);
                check("busy_in_done", busy, 0);
            end
            if (stall == 0) begin
                out_ready = 1'b1;
                have = 0;
                hs_pending = 1;
            end else begin
                out_ready = 1'b0;
                stall--;
            end
        end else begin
            // out_ready outside DONE must have no effect
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver ----------------
    // Returns at the negedge after the acceptance edge (first BUSY cycle) unless
    // hold is set, in which case it keeps in_valid high with junk operands until
    // the block leaves BUSY.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("issue_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        a = x;
        b = y;
        q.push_back('{prod: model(x, y), acc: cyc + 1});
        @(negedge clk);
        check("busy_after_accept", busy, 1);
        check("in_ready_after_accept", in_ready, 0);
        if (hold) begin
            a = 8'd7;
            b = 8'd7;
            t = 0;
            while (busy && t < 100) begin
                @(negedge clk);
                a = W'($urandom);
                b = W'($urandom);
                t++;
            end
        end else begin
            a = W'($urandom);
            b = W'($urandom);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_p", p, 0);
        check("reset_busy", busy, 0);

        // directed corner cases
        issue(8'hFF, 8'hFF, 0);
        issue(8'h00, 8'hA5, 0);
        issue(8'hA5, 8'h00, 0);
        force_stall = 5;
        issue(8'd13, 8'd11, 0);
        issue(8'd3, 8'd5, 1);      // operands change with in_valid high during BUSY
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        issue(8'hFD, 8'd5, 0);     // -3 * 5
        issue(8'h80, 8'h80, 0);    // -128 * -128
        issue(8'd127, 8'hFF, 0);   // 127 * -1
        issue(8'h80, 8'd1, 0);
`endif

        // reset in the middle of an operation
        issue(8'd9, 8'd9, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        #1;
        check("midreset_p", p, 0);
        check("midreset_in_ready", in_ready, 1);
        check("midreset_out_valid", out_valid, 0);
        check("midreset_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * N + 4) @(negedge clk);   // monitor flags any stray out_valid
        issue(8'd2, 8'd6, 0);

        // randomized stream, back-to-back where the consumer allows
        for (int i = 0; i < 30; i++)
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 3) == 0));

        t = 0;
        while ((q.size() != 0 || have) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", (q.size() == 0 && !have) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
